// File: rtl/verificador_faixa_if.sv
// Bundle between the HC-SR04 front end and the band checker: measurement
// strobe, BCD distance and band limits in, verdict and debug signals out.
interface verificador_faixa_if;
   logic        habilita;
   logic        pronto;
   logic [11:0] medida;
   logic [11:0] upperL;
   logic [11:0] lowerL;
   logic        dentro;
   logic        acertou;
   logic        erro;
   logic [3:0]  db_contagem;
   logic [3:0]  db_estado;

   modport master (
      output habilita, pronto, medida, upperL, lowerL,
      input  dentro, acertou, erro, db_contagem, db_estado
   );

   modport slave (
      input  habilita, pronto, medida, upperL, lowerL,
      output dentro, acertou, erro, db_contagem, db_estado
   );
endinterface

// File: rtl/verificador_faixa.sv
// Checks each completed BCD distance against an inclusive band, counts
// consecutive hits, and flags invalid digits or a missing measurement.
module verificador_faixa #(
   parameter int N_ACERTOS      = 4,
   parameter int TIMEOUT_CICLOS = 5_000_000
) (
   input logic           clock,
   input logic           reset,
   verificador_faixa_if.slave faixa
);

   localparam int TW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CICLOS - 1);
   localparam logic [3:0]    N_ALVO      = 4'(N_ACERTOS);

   typedef enum logic [3:0] {
      OCIOSO  = 4'd0,
      ESPERA  = 4'd1,
      AVALIA  = 4'd2,
      ACERTOU = 4'd3
   } estado_t;

   estado_t       estado;
   logic          pronto_q;
   logic [11:0]   medida_q;
   logic [TW-1:0] timeout_cnt;
   logic          dentro_q;
   logic          acertou_q;
   logic          erro_q;
   logic [3:0]    contagem;

   logic          pronto_ev;
   logic          bcd_valido;
   logic          na_faixa;
   logic [3:0]    contagem_prox;

   // Plain binary compare is only meaningful because every digit was validated first.
   assign pronto_ev     = faixa.pronto & ~pronto_q;
   assign bcd_valido    = (medida_q[3:0] <= 4'd9) && (medida_q[7:4] <= 4'd9)
                          && (medida_q[11:8] <= 4'd9);
   assign na_faixa      = (faixa.lowerL <= medida_q) && (medida_q <= faixa.upperL);
   assign contagem_prox = !na_faixa ? 4'd0
                        : (contagem == 4'hF) ? 4'hF : contagem + 4'd1;

   always_ff @(posedge clock) begin
      if (reset || !faixa.habilita) begin
         estado      <= OCIOSO;
         pronto_q    <= 1'b0;
         medida_q    <= 12'd0;
         timeout_cnt <= '0;
         dentro_q    <= 1'b0;
         acertou_q   <= 1'b0;
         erro_q      <= 1'b0;
         contagem    <= 4'd0;
      end else begin
         pronto_q <= faixa.pronto;
         erro_q   <= 1'b0;
         case (estado)
            OCIOSO: estado <= ESPERA;
            // ACERTOU waits exactly like ESPERA; only the return state differs.
            ESPERA, ACERTOU: begin
               if (pronto_ev) begin
                  medida_q    <= faixa.medida;
                  timeout_cnt <= '0;
                  estado      <= AVALIA;
               end else if (timeout_cnt == TIMEOUT_MAX) begin
                  erro_q      <= 1'b1;
                  contagem    <= 4'd0;
                  dentro_q    <= 1'b0;
                  timeout_cnt <= '0;
               end else begin
                  timeout_cnt <= timeout_cnt + TW'(1);
               end
            end
            AVALIA: begin
               if (!bcd_valido) begin
                  erro_q <= 1'b1;
                  estado <= acertou_q ? ACERTOU : ESPERA;
               end else begin
                  dentro_q <= na_faixa;
                  contagem <= contagem_prox;
                  if (na_faixa && (contagem_prox == N_ALVO)) begin
                     acertou_q <= 1'b1;
                     estado    <= ACERTOU;
                  end else begin
                     estado <= acertou_q ? ACERTOU : ESPERA;
                  end
               end
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

   assign faixa.dentro      = dentro_q;
   assign faixa.acertou     = acertou_q;
   assign faixa.erro        = erro_q;
   assign faixa.db_contagem = contagem;
   assign faixa.db_estado   = estado;

endmodule

// File: tb/tb_verificador_faixa.sv
// Self-checking bench for verificador_faixa: table of measurements scored
// through an expectation queue, plus timeout, enable and held-pronto sequences.
module tb_verificador_faixa;

   typedef struct {
      logic        rst;
      logic [11:0] medida;
      logic [11:0] lower;
      logic [11:0] upper;
      logic        dentro;
      logic [3:0]  contagem;
      logic        acertou;
      logic        erro;
      logic [3:0]  estado;
   } vetor_t;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_erros;
   vetor_t tabela[$];
   vetor_t exp_q[$];

   verificador_faixa_if bus_if();

   verificador_faixa #(
      .N_ACERTOS(4),
      .TIMEOUT_CICLOS(100)
   ) dut (
      .clock(clock),
      .reset(reset),
      .faixa(bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vetor_t vec(input logic r, input logic [11:0] m,
                                  input logic [11:0] lo, input logic [11:0] up,
                                  input logic d, input logic [3:0] c,
                                  input logic a, input logic e, input logic [3:0] s);
      vetor_t v;
      v.rst = r; v.medida = m; v.lower = lo; v.upper = up;
      v.dentro = d; v.contagem = c; v.acertou = a; v.erro = e; v.estado = s;
      return v;
   endfunction

   task automatic check(input string nome, input logic [11:0] atual, input logic [11:0] esperado);
      n_checks++;
      if (atual !== esperado) begin
         n_erros++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
      end
   endtask

   task automatic check_zero(input string onde);
      check({onde, " dentro"},   12'(bus_if.dentro),      12'd0);
      check({onde, " acertou"},  12'(bus_if.acertou),     12'd0);
      check({onde, " erro"},     12'(bus_if.erro),        12'd0);
      check({onde, " contagem"}, 12'(bus_if.db_contagem), 12'd0);
      check({onde, " estado"},   12'(bus_if.db_estado),   12'd0);
   endtask

   task automatic reset_dut();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_zero("reset");
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("pos_reset estado", 12'(bus_if.db_estado), 12'd1);
   endtask

   task automatic check_output();
      vetor_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_erros++;
         $display("[TB] FAIL scoreboard: got empty queue expected pending entry");
      end else begin
         e = exp_q.pop_front();
         check("dentro",   12'(bus_if.dentro),      12'(e.dentro));
         check("contagem", 12'(bus_if.db_contagem), 12'(e.contagem));
         check("acertou",  12'(bus_if.acertou),     12'(e.acertou));
         check("erro",     12'(bus_if.erro),        12'(e.erro));
         check("estado",   12'(bus_if.db_estado),   12'(e.estado));
         if (e.erro) begin
            @(posedge clock);
            #1;
            check("erro_um_ciclo", 12'(bus_if.erro), 12'd0);
         end
      end
   endtask

   // Result is valid after the second edge following the pronto rise.
   task automatic apply_stimulus(input vetor_t v);
      if (v.rst) reset_dut();
      @(negedge clock);
      bus_if.medida = v.medida;
      bus_if.lowerL = v.lower;
      bus_if.upperL = v.upper;
      bus_if.pronto = 1'b1;
      exp_q.push_back(v);
      @(posedge clock);
      @(negedge clock);
      bus_if.pronto = 1'b0;
      @(posedge clock);
      #1;
      check_output();
   endtask

   initial begin
      int erro_cedo;
      n_checks = 0;
      n_erros  = 0;
      reset = 1'b1;
      bus_if.habilita = 1'b1;
      bus_if.pronto   = 1'b0;
      bus_if.medida   = 12'h000;
      bus_if.lowerL   = 12'h070;
      bus_if.upperL   = 12'h080;

      tabela.push_back(vec(1'b1, 12'h075, 12'h070, 12'h080, 1'b1, 4'd1, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h075, 12'h070, 12'h080, 1'b1, 4'd2, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h075, 12'h070, 12'h080, 1'b1, 4'd3, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h075, 12'h070, 12'h080, 1'b1, 4'd4, 1'b1, 1'b0, 4'd3));
      tabela.push_back(vec(1'b0, 12'h100, 12'h070, 12'h080, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3));
      tabela.push_back(vec(1'b0, 12'h075, 12'h070, 12'h080, 1'b1, 4'd1, 1'b1, 1'b0, 4'd3));
      tabela.push_back(vec(1'b1, 12'h075, 12'h070, 12'h080, 1'b1, 4'd1, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h075, 12'h070, 12'h080, 1'b1, 4'd2, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h100, 12'h070, 12'h080, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h075, 12'h070, 12'h080, 1'b1, 4'd1, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h070, 12'h070, 12'h080, 1'b1, 4'd2, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h080, 12'h070, 12'h080, 1'b1, 4'd3, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h069, 12'h070, 12'h080, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h081, 12'h070, 12'h080, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h075, 12'h080, 12'h070, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h075, 12'h070, 12'h080, 1'b1, 4'd1, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h075, 12'h070, 12'h080, 1'b1, 4'd2, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h07A, 12'h070, 12'h080, 1'b1, 4'd2, 1'b0, 1'b1, 4'd1));
      tabela.push_back(vec(1'b0, 12'hA00, 12'h000, 12'h999, 1'b1, 4'd2, 1'b0, 1'b1, 4'd1));
      tabela.push_back(vec(1'b0, 12'h999, 12'h000, 12'h999, 1'b1, 4'd3, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b1, 12'h075, 12'h070, 12'h080, 1'b1, 4'd1, 1'b0, 1'b0, 4'd1));
      tabela.push_back(vec(1'b0, 12'h000, 12'h000, 12'h000, 1'b1, 4'd2, 1'b0, 1'b0, 4'd1));

      foreach (tabela[i]) apply_stimulus(tabela[i]);

      // Timeout: one hit, then silence until the counter expires.
      apply_stimulus(vec(1'b1, 12'h075, 12'h070, 12'h080, 1'b1, 4'd1, 1'b0, 1'b0, 4'd1));
      erro_cedo = 0;
      for (int i = 0; i < 99; i++) begin
         @(posedge clock);
         #1;
         if (bus_if.erro) erro_cedo++;
      end
      check("timeout_cedo", 12'(erro_cedo), 12'd0);
      @(posedge clock);
      #1;
      check("timeout erro",     12'(bus_if.erro),        12'd1);
      check("timeout contagem", 12'(bus_if.db_contagem), 12'd0);
      check("timeout dentro",   12'(bus_if.dentro),      12'd0);
      check("timeout estado",   12'(bus_if.db_estado),   12'd1);
      @(posedge clock);
      #1;
      check("timeout pulso", 12'(bus_if.erro), 12'd0);

      // habilita dropped while latched in ACERTOU.
      for (int i = 1; i <= 4; i++)
         apply_stimulus(vec(1'b0, 12'h075, 12'h070, 12'h080, 1'b1, 4'(i),
                            (i == 4), 1'b0, (i == 4) ? 4'd3 : 4'd1));
      @(negedge clock);
      bus_if.habilita = 1'b0;
      @(posedge clock);
      #1;
      check_zero("habilita");
      @(negedge clock);
      bus_if.habilita = 1'b1;
      @(posedge clock);
      #1;
      check("reabilita estado", 12'(bus_if.db_estado), 12'd1);

      // pronto held high for 50 cycles is a single measurement.
      @(negedge clock);
      bus_if.medida = 12'h075;
      bus_if.pronto = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("pronto_longo contagem", 12'(bus_if.db_contagem), 12'd1);
      repeat (48) @(posedge clock);
      #1;
      check("pronto_longo final", 12'(bus_if.db_contagem), 12'd1);
      check("pronto_longo estado", 12'(bus_if.db_estado), 12'd1);
      @(negedge clock);
      bus_if.pronto = 1'b0;
      apply_stimulus(vec(1'b0, 12'h075, 12'h070, 12'h080, 1'b1, 4'd2, 1'b0, 1'b0, 4'd1));

      // habilita dropped during evaluation discards the pending result.
      @(negedge clock);
      bus_if.pronto = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus_if.habilita = 1'b0;
      bus_if.pronto   = 1'b0;
      @(posedge clock);
      #1;
      check_zero("meio_avalia");
      @(negedge clock);
      bus_if.habilita = 1'b1;
      @(posedge clock);
      #1;
      check("meio_avalia retorno", 12'(bus_if.db_estado), 12'd1);
      apply_stimulus(vec(1'b0, 12'h075, 12'h070, 12'h080, 1'b1, 4'd1, 1'b0, 1'b0, 4'd1));

      $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
      $finish;
   end

endmodule

// File: doc/verificador_faixa.md
Name: verificador_faixa

Overview:
Downstream consumer of the HC-SR04 interface measurement inside medidor_faixa. Takes each completed 3-digit BCD distance (cm) with its "pronto" strobe and checks it against an inclusive BCD band [lowerL, upperL]. Counts consecutive in-band measurements and latches "acertou" once N_ACERTOS consecutive hits occur. Also flags invalid BCD and a missing-measurement timeout.

Parameters:
N_ACERTOS, 4, consecutive in-band measurements needed to assert acertou (1..15)
TIMEOUT_CICLOS, 5_000_000, clock cycles in ESPERA without a new measurement before timeout (100 ms at 50 MHz)

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
habilita  in  1  enables checking; low forces OCIOSO
pronto  in  1  measurement-complete from interface; rising edge consumed
medida  in  12  BCD distance {centenas, dezenas, unidades}, cm
upperL  in  12  BCD upper limit, inclusive
lowerL  in  12  BCD lower limit, inclusive
dentro  out  1  last accepted measurement in band
acertou  out  1  latched: N_ACERTOS consecutive in-band measurements reached
erro  out  1  one-cycle pulse: invalid BCD or timeout
db_contagem  out  4  current consecutive-hit count
db_estado  out  4  FSM state code

Behaviour:
- Reset (synchronous, active-high) or habilita=0: state OCIOSO. dentro=0, acertou=0, erro=0, db_contagem=0, timeout counter=0, pronto edge register=0.
- State codes: OCIOSO=0, ESPERA=1, AVALIA=2, ACERTOU=3.
- OCIOSO -> ESPERA on the first edge with habilita=1.
- Edge detection: pronto_ev = pronto & ~pronto_q. A held-high pronto is one event. Edge register updates in every state.
- ESPERA:
  - On pronto_ev at edge k: latch medida into an internal register and go to AVALIA. Clear the timeout counter.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT_CICLOS-1: erro=1 for one cycle, db_contagem=0, dentro=0, counter cleared, stay in ESPERA. acertou is unaffected.
- AVALIA (edge k+1): all result outputs are valid after edge k+1, so latency is 2 edges from the pronto rising edge.
  - Any latched nibble >9: measurement discarded. erro pulses one cycle. dentro and db_contagem unchanged. Go to ESPERA.
  - Otherwise compute in = (lowerL <= m) && (m <= upperL). Compare as 12-bit unsigned, which is valid because every digit is valid BCD.
  - lowerL and upperL are sampled during AVALIA. lowerL > upperL means in is always 0.
  - dentro <= in.
  - If in=1, db_contagem increments, saturating at 15. If in=0, db_contagem resets to 0.
  - If the new count equals N_ACERTOS: acertou <= 1 and go to ACERTOU. Otherwise go to ESPERA.
- ACERTOU:
  - acertou is held at 1 until reset or habilita=0.
  - Measurements keep being evaluated: ACERTOU behaves like ESPERA, but returns to ACERTOU after evaluation.
  - dentro and db_contagem keep updating; the timeout also applies.
  - An out-of-band measurement clears db_contagem but does not clear acertou.
- A pronto_ev arriving while in AVALIA is ignored; the interface cannot produce events spaced 1 cycle apart.
- habilita falling mid-AVALIA: OCIOSO on that edge, and the pending result is discarded.

Test Plan:
1. lowerL=070, upperL=080, habilita=1; four pronto pulses with medida=075 (12'h075) -> db_contagem 1,2,3,4; acertou=1 two edges after the 4th pronto rise; db_estado=3.
2. Sequence 075,075,100,075 -> dentro 1,1,0,1; db_contagem 1,2,0,1; acertou stays 0.
3. Boundaries 070, 080, 069, 081 -> dentro 1,1,0,0. Then limits 080/070 (swapped) with medida 075 -> dentro=0.
4. medida=12'h07A after two hits -> erro pulses for exactly 1 cycle; db_contagem stays 2; dentro unchanged.
5. TIMEOUT_CICLOS=100, one hit followed by no pronto for 100 cycles -> erro pulse at cycle 100; db_contagem=0; dentro=0; state stays 1.
6. reset=1 for one cycle after 3 hits, and separately habilita=0 while in ACERTOU -> all outputs 0, db_estado=0; pronto held high for 50 cycles counts as one measurement.
